// File: rtl/ce_sc_demap.sv
// Used-subcarrier demapper: drops DC and guard bins of a natural-order FFT frame and
// reorders the occupied bins to negative-first, holding the positive half in a buffer.
module ce_sc_demap #(
    parameter int wData   = 16,
    parameter int maxHalf = 600
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sink_valid,
    input  logic             sink_sop,
    input  logic             sink_eop,
    output logic             sink_ready,
    input  logic [wData-1:0] sink_real,
    input  logic [wData-1:0] sink_imag,
    input  logic [11:0]      fftpts_in,
    input  logic [10:0]      used_in,
    output logic             source_valid,
    output logic             source_sop,
    output logic             source_eop,
    input  logic             source_ready,
    output logic [wData-1:0] source_real,
    output logic [wData-1:0] source_imag,
    output logic [11:0]      fftpts_out,
    output logic [1:0]       source_error
);
    localparam int AW = 10;

    typedef enum logic [2:0] {IDLE, BUF, SKIP, PASS, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [11:0]        k_q, k_d, n_q, n_d, fftpts_q, fftpts_d;
    logic [AW-1:0]      h_q, h_d, rd_addr_q, rd_addr_d, rd_idx_q, rd_idx_d;
    logic               rd_vld_q, rd_vld_d;
    logic               vld_q, vld_d, sop_q, sop_d, eop_q, eop_d;
    logic [wData-1:0]   re_q, re_d, im_q, im_d;
    logic [1:0]         err_q, err_d;
    logic [2*wData-1:0] mem [maxHalf];
    logic [2*wData-1:0] rd_data_q;
    logic               wr_en, rd_en, accept, last, drain_done, idle_eff;
    logic [11:0]        nh, km1;
    logic               unused_bits;

    assign unused_bits = used_in[0];
    assign nh          = n_q - {2'b00, h_q};
    assign km1         = k_q - 12'd1;
    assign last        = (k_q == n_q - 12'd1);
    // The eop beat leaves the buffer this cycle, so a new sop may be taken at the same edge.
    assign drain_done  = (state_q == DRAIN) && source_ready && rd_vld_q && (rd_idx_q == h_q - 10'd1);
    assign idle_eff    = (state_q == IDLE) || drain_done;
    assign accept      = sink_valid && sink_ready;

    always_comb begin
        case (state_q)
            PASS:    sink_ready = source_ready;
            DRAIN:   sink_ready = drain_done;
            default: sink_ready = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        n_d       = n_q;
        h_d       = h_q;
        fftpts_d  = fftpts_q;
        rd_addr_d = rd_addr_q;
        rd_idx_d  = rd_idx_q;
        rd_vld_d  = rd_vld_q;
        vld_d     = source_ready ? 1'b0 : vld_q;
        sop_d     = source_ready ? 1'b0 : sop_q;
        eop_d     = source_ready ? 1'b0 : eop_q;
        re_d      = re_q;
        im_d      = im_q;
        err_d     = 2'b00;
        wr_en     = 1'b0;
        rd_en     = 1'b0;

        if (state_q == DRAIN && source_ready) begin
            vld_d = rd_vld_q;
            eop_d = drain_done;
            if (rd_vld_q) {re_d, im_d} = rd_data_q;
            if (drain_done) begin
                state_d  = IDLE;
                rd_vld_d = 1'b0;
            end else if (rd_addr_q < h_q) begin
                rd_en     = 1'b1;
                rd_vld_d  = 1'b1;
                rd_idx_d  = rd_addr_q;
                rd_addr_d = rd_addr_q + 10'd1;
            end else begin
                rd_vld_d = 1'b0;
            end
        end

        if (accept && sink_sop) begin
            err_d[0]  = !idle_eff;
            err_d[1]  = sink_eop;
            n_d       = fftpts_in;
            h_d       = used_in[10:1];
            fftpts_d  = fftpts_in;
            k_d       = 12'd1;
            state_d   = BUF;
            rd_vld_d  = 1'b0;
            rd_addr_d = '0;
        end else if (accept && !idle_eff) begin
            err_d[1] = sink_eop ^ last;
            k_d      = k_q + 12'd1;
            case (state_q)
                BUF: begin
                    wr_en = 1'b1;
                    if (k_q == {2'b00, h_q}) state_d = SKIP;
                end
                SKIP: if (k_q == nh - 12'd1) state_d = PASS;
                PASS: begin
                    vld_d = 1'b1;
                    sop_d = (k_q == nh);
                    eop_d = 1'b0;
                    re_d  = sink_real;
                    im_d  = sink_imag;
                    if (last) begin
                        state_d   = DRAIN;
                        rd_addr_d = '0;
                        rd_vld_d  = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            k_q       <= '0;
            n_q       <= '0;
            h_q       <= '0;
            fftpts_q  <= '0;
            rd_addr_q <= '0;
            rd_idx_q  <= '0;
            rd_vld_q  <= 1'b0;
            vld_q     <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            re_q      <= '0;
            im_q      <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            n_q       <= n_d;
            h_q       <= h_d;
            fftpts_q  <= fftpts_d;
            rd_addr_q <= rd_addr_d;
            rd_idx_q  <= rd_idx_d;
            rd_vld_q  <= rd_vld_d;
            vld_q     <= vld_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            re_q      <= re_d;
            im_q      <= im_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && km1 < 12'(maxHalf)) mem[km1[AW-1:0]] <= {sink_real, sink_imag};
        if (rd_en) rd_data_q <= mem[rd_addr_q];
    end

    assign source_valid = vld_q;
    assign source_sop   = sop_q;
    assign source_eop   = eop_q;
    assign source_real  = re_q;
    assign source_imag  = im_q;
    assign fftpts_out   = fftpts_q;
    assign source_error = err_q;
endmodule

// File: tb/tb_ce_sc_demap.sv
// Bench for ce_sc_demap: drives ramp and random frames, predicts the demapped
// output order from bin arithmetic and compares every beat.
module tb_ce_sc_demap;
    localparam int W = 16;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         sink_valid = 0, sink_sop = 0, sink_eop = 0, sink_ready;
    logic [W-1:0] sink_real = '0, sink_imag = '0;
    logic [11:0]  fftpts_in = '0;
    logic [10:0]  used_in = '0;
    logic         source_valid, source_sop, source_eop, source_ready = 1'b1;
    logic [W-1:0] source_real, source_imag;
    logic [11:0]  fftpts_out;
    logic [1:0]   source_error;

    ce_sc_demap #(.wData(W), .maxHalf(600)) dut (
        .clk(clk), .rst_n(rst_n),
        .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_ready(sink_ready),
        .sink_real(sink_real), .sink_imag(sink_imag), .fftpts_in(fftpts_in), .used_in(used_in),
        .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
        .source_ready(source_ready), .source_real(source_real), .source_imag(source_imag),
        .fftpts_out(fftpts_out), .source_error(source_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         sop;
        logic         eop;
        logic [W-1:0] re;
        logic [W-1:0] im;
    } beat_t;

    beat_t        exp_q[$], got_q[$];
    beat_t        mb;
    logic [W-1:0] din_re [2048];
    logic [W-1:0] din_im [2048];
    int           acc_edge [2048];
    int           n_tests = 0, n_fail = 0, cyc = 0;
    int           first_edge = -1, first_acc = 0, last_acc = 0;
    int           err0_cnt = 0, err1_cnt = 0, eop_cnt = 0, rdy_low = 0;
    bit           rnd_ready = 0, timeout = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (rnd_ready) begin
        #1 source_ready = ($urandom_range(0, 1) == 1);
    end

    always @(negedge clk) if (rst_n) begin
        if (source_valid && source_ready) begin
            mb = {source_sop, source_eop, source_real, source_imag};
            got_q.push_back(mb);
            if (first_edge < 0) first_edge <= cyc + 1;
            if (source_eop) eop_cnt <= eop_cnt + 1;
        end
        err0_cnt <= err0_cnt + int'(source_error[0]);
        err1_cnt <= err1_cnt + int'(source_error[1]);
        if (!sink_ready) rdy_low <= rdy_low + 1;
    end

    task automatic fill_ramp(input int off);
        for (int k = 0; k < 2048; k++) begin
            din_re[k] = 16'(k + off);
            din_im[k] = 16'(-(k + off));
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 2048; k++) begin
            din_re[k] = 16'($urandom);
            din_im[k] = 16'($urandom);
        end
    endtask

    // Reference: output j is bin N-H+j for the negative half, then bin j-H+1.
    task automatic model(input int n, input int h);
        beat_t b;
        int    bin;
        for (int j = 0; j < 2 * h; j++) begin
            bin   = (j < h) ? (n - h + j) : (j - h + 1);
            b.sop = (j == 0);
            b.eop = (j == 2 * h - 1);
            b.re  = din_re[bin];
            b.im  = din_im[bin];
            exp_q.push_back(b);
        end
    endtask

    task automatic drive_frame(input int n, input int used, input int kmax, input int eop_k);
        bit acc;
        int waitc;
        for (int k = 0; k < kmax; k++) begin
            acc        = 0;
            waitc      = 0;
            sink_valid = 1;
            sink_sop   = (k == 0);
            sink_eop   = (k == eop_k);
            sink_real  = din_re[k];
            sink_imag  = din_im[k];
            fftpts_in  = n[11:0];
            used_in    = used[10:0];
            while (!acc && !timeout) begin
                @(negedge clk);
                acc = sink_ready;
                @(posedge clk);
                #1;
                waitc++;
                if (waitc > 5000) timeout = 1;
            end
            acc_edge[k] = cyc;
            if (k == 0) first_acc = cyc;
            last_acc = cyc;
            if (timeout) break;
        end
        sink_valid = 0;
        sink_sop   = 0;
        sink_eop   = 0;
    endtask

    task automatic wait_out();
        int c = 0;
        while (got_q.size() < exp_q.size() && c < 20000) begin
            @(posedge clk);
            c++;
        end
        if (c >= 20000) timeout = 1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic start_scn();
        got_q.delete();
        exp_q.delete();
        first_edge = -1;
        err0_cnt   = 0;
        err1_cnt   = 0;
        eop_cnt    = 0;
        rdy_low    = 0;
        timeout    = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        n_tests += 4;
        if (source_valid !== 1'b0 || source_sop !== 1'b0 || source_eop !== 1'b0) begin
            n_fail++; $display("FAIL reset_framing got v/s/e=%b%b%b exp 000", source_valid, source_sop, source_eop);
        end
        if (source_real !== '0 || source_imag !== '0) begin
            n_fail++; $display("FAIL reset_data got %h/%h exp 0/0", source_real, source_imag);
        end
        if (source_error !== 2'b00 || fftpts_out !== 12'd0) begin
            n_fail++; $display("FAIL reset_err_fft got %b/%0d exp 00/0", source_error, fftpts_out);
        end
        if (sink_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_sink_ready got %b exp 1", sink_ready);
        end
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ramp_2048();
        int bad = 0;
        start_scn();
        fill_ramp(0);
        model(2048, 600);
        drive_frame(2048, 1200, 2048, 2047);
        wait_out();
        n_tests += 5;
        if (timeout) begin n_fail++; $display("FAIL ramp2048_timeout got beats=%0d exp 1200", got_q.size()); end
        if (got_q.size() != 1200) begin n_fail++; $display("FAIL ramp2048_count got %0d exp 1200", got_q.size()); end
        if (fftpts_out !== 12'd2048) begin n_fail++; $display("FAIL ramp2048_fftpts got %0d exp 2048", fftpts_out); end
        if (first_edge - acc_edge[1448] != 1) begin
            n_fail++; $display("FAIL ramp2048_latency got %0d exp 1", first_edge - acc_edge[1448]);
        end
        if (eop_cnt != 1 || err0_cnt != 0 || err1_cnt != 0) begin
            n_fail++; $display("FAIL ramp2048_flags got eop=%0d e0=%0d e1=%0d exp 1/0/0", eop_cnt, err0_cnt, err1_cnt);
        end
        foreach (exp_q[i]) begin
            n_tests++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                if (bad++ < 4) $display("FAIL ramp2048_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_small_128();
        int bad = 0;
        start_scn();
        fill_ramp(0);
        model(128, 36);
        drive_frame(128, 72, 128, 127);
        wait_out();
        n_tests += 3;
        if (timeout || got_q.size() != 72) begin n_fail++; $display("FAIL n128_count got %0d exp 72", got_q.size()); end
        if (rdy_low != 36) begin n_fail++; $display("FAIL n128_ready_low got %0d exp 36", rdy_low); end
        if (got_q.size() > 71 && (got_q[0].re !== 16'd92 || got_q[35].re !== 16'd127 || got_q[36].re !== 16'd1 || got_q[71].re !== 16'd36)) begin
            n_fail++; $display("FAIL n128_marks got %0d/%0d/%0d/%0d exp 92/127/1/36",
                               got_q[0].re, got_q[35].re, got_q[36].re, got_q[71].re);
        end
        foreach (exp_q[i]) begin
            n_tests++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                if (bad++ < 4) $display("FAIL n128_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_stall();
        int bad = 0;
        start_scn();
        fill_ramp(0);
        model(2048, 600);
        rnd_ready = 1;
        drive_frame(2048, 1200, 2048, 2047);
        wait_out();
        rnd_ready = 0;
        @(posedge clk);
        #2 source_ready = 1;
        n_tests += 2;
        if (timeout || got_q.size() != 1200) begin n_fail++; $display("FAIL stall_count got %0d exp 1200", got_q.size()); end
        if (eop_cnt != 1) begin n_fail++; $display("FAIL stall_eop got %0d exp 1", eop_cnt); end
        foreach (exp_q[i]) begin
            n_tests++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                if (bad++ < 4) $display("FAIL stall_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0, t1, t2;
        start_scn();
        fill_ramp(0);
        model(512, 150);
        drive_frame(512, 300, 512, 511);
        t1 = last_acc;
        fill_ramp(1000);
        model(512, 150);
        drive_frame(512, 300, 512, 511);
        t2 = first_acc;
        wait_out();
        n_tests += 3;
        if (timeout || got_q.size() != 600) begin n_fail++; $display("FAIL b2b_count got %0d exp 600", got_q.size()); end
        if (t2 - t1 != 151) begin n_fail++; $display("FAIL b2b_sop_gap got %0d exp 151", t2 - t1); end
        if (got_q.size() > 300 && (got_q[300].re !== 16'd1362 || got_q[300].sop !== 1'b1)) begin
            n_fail++; $display("FAIL b2b_out0 got %0d sop=%b exp 1362 sop=1", got_q[300].re, got_q[300].sop);
        end
        foreach (exp_q[i]) begin
            n_tests++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                if (bad++ < 4) $display("FAIL b2b_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_abort();
        int bad = 0;
        start_scn();
        fill_ramp(0);
        model(2048, 600);
        drive_frame(2048, 1200, 700, -1);
        drive_frame(2048, 1200, 2048, 2047);
        wait_out();
        n_tests += 3;
        if (timeout || got_q.size() != 1200) begin n_fail++; $display("FAIL abort_count got %0d exp 1200", got_q.size()); end
        if (err0_cnt != 1) begin n_fail++; $display("FAIL abort_err0 got %0d exp 1", err0_cnt); end
        if (eop_cnt != 1 || err1_cnt != 0) begin n_fail++; $display("FAIL abort_eop got eop=%0d e1=%0d exp 1/0", eop_cnt, err1_cnt); end
        foreach (exp_q[i]) begin
            n_tests++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                if (bad++ < 4) $display("FAIL abort_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_eop_error();
        int bad = 0;
        start_scn();
        fill_ramp(0);
        model(128, 36);
        drive_frame(128, 72, 128, 10);
        wait_out();
        n_tests += 2;
        if (err1_cnt != 2) begin n_fail++; $display("FAIL eoperr_err1 got %0d exp 2", err1_cnt); end
        if (err0_cnt != 0) begin n_fail++; $display("FAIL eoperr_err0 got %0d exp 0", err0_cnt); end
        foreach (exp_q[i]) begin
            n_tests++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                if (bad++ < 4) $display("FAIL eoperr_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int n, h, hmax, bad;
        for (int it = 0; it < 3; it++) begin
            bad  = 0;
            n    = 128 << $urandom_range(0, 4);
            hmax = ((n - 2) / 2 < 600) ? (n - 2) / 2 : 600;
            h    = $urandom_range(1, hmax);
            start_scn();
            fill_rand();
            model(n, h);
            rnd_ready = 1;
            drive_frame(n, 2 * h, n, n - 1);
            wait_out();
            rnd_ready = 0;
            @(posedge clk);
            #2 source_ready = 1;
            n_tests += 2;
            if (timeout || got_q.size() != 2 * h) begin
                n_fail++; $display("FAIL rand%0d_count N=%0d H=%0d got %0d exp %0d", it, n, h, got_q.size(), 2 * h);
            end
            if (fftpts_out !== 12'(n)) begin n_fail++; $display("FAIL rand%0d_fftpts got %0d exp %0d", it, fftpts_out, n); end
            foreach (exp_q[i]) begin
                n_tests++;
                if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    if (bad++ < 4) $display("FAIL rand%0d_beat%0d got %h exp %h", it, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        int bad = 0;
        start_scn();
        fill_ramp(0);
        drive_frame(2048, 1200, 2048, 2047);
        repeat (100) @(posedge clk);
        #2 rst_n = 0;
        #1;
        n_tests += 2;
        if (source_valid !== 1'b0 || source_sop !== 1'b0 || source_eop !== 1'b0 || source_error !== 2'b00) begin
            n_fail++; $display("FAIL rstdrain_framing got v/s/e/err=%b%b%b/%b exp 000/00", source_valid, source_sop, source_eop, source_error);
        end
        if (source_real !== '0 || source_imag !== '0 || fftpts_out !== '0) begin
            n_fail++; $display("FAIL rstdrain_data got %h/%h/%0d exp 0/0/0", source_real, source_imag, fftpts_out);
        end
        @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk);
        #1;
        n_tests++;
        if (sink_ready !== 1'b1) begin n_fail++; $display("FAIL rstdrain_ready got %b exp 1", sink_ready); end
        start_scn();
        model(128, 36);
        drive_frame(128, 72, 128, 127);
        wait_out();
        n_tests++;
        if (timeout || got_q.size() != 72) begin n_fail++; $display("FAIL rstdrain_count got %0d exp 72", got_q.size()); end
        foreach (exp_q[i]) begin
            n_tests++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                if (bad++ < 4) $display("FAIL rstdrain_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp_2048();
        test_small_128();
        test_stall();
        test_back_to_back();
        test_abort();
        test_eop_error();
        test_random();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ce_sc_demap.md
# ce_sc_demap

Used-subcarrier demapper placed directly upstream of the least-square stage. It takes one natural-order FFT output frame of `fftpts_in` bins and discards DC and the guard bins. It emits the `used_in` occupied subcarriers as one contiguous frame, negative-frequency bins first, then positive. The positive half arrives first from the FFT, so it is held in an internal buffer until the negative half has passed through.

## Interface
Parameters:
- `wData`, 16: real/imag sample width, signed.
- `maxHalf`, 600: buffer depth in samples; the largest supported `used_in/2`.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `sink_valid` / `sink_sop` / `sink_eop`, in, 1 each: input frame framing, bin 0 carries sop.
- `sink_ready`, out, 1: input accept.
- `sink_real` / `sink_imag`, in, `wData`: FFT bin, signed.
- `fftpts_in`, in, 12: FFT size, power of 2, 128..2048; sampled on accepted sop.
- `used_in`, in, 11: used subcarriers; even, ≤ 2·`maxHalf`, ≤ `fftpts_in`−2; sampled on accepted sop.
- `source_valid` / `source_sop` / `source_eop`, out, 1 each: output framing.
- `source_ready`, in, 1: downstream ready, used as a stall.
- `source_real` / `source_imag`, out, `wData`: demapped subcarrier.
- `fftpts_out`, out, 12: `fftpts_in` value latched at the frame's sop.
- `source_error`, out, 2: bit0 = frame aborted by early sop; bit1 = eop mismatch. One-cycle pulses.

## Operation
- Definitions: N = latched fftpts, H = latched used/2, k = bin index of an accepted input sample (0..N−1).
- An accepted sample is one with `sink_valid & sink_ready`.
- Input bin k is handled as follows:
  - k=0 (DC): dropped.
  - k = 1..H: written to buffer address k−1.
  - k = H+1..N−H−1: dropped.
  - k = N−H..N−1: passed to output as output indices 0..H−1.
- After k=N−1 is accepted, buffer addresses 0..H−1 are read out as output indices H..2H−1.
- Output frame: `source_sop` on index 0, `source_eop` on index 2H−1; exactly 2H valid beats per frame.
- State machine:
  - IDLE: wait for an accepted sop.
  - BUF: k = 1..H.
  - SKIP: guard bins.
  - PASS: negative bins.
  - DRAIN: buffer readout, returns to IDLE after index 2H−1 is emitted.
  - From IDLE, the accepted sop sample (k=0) moves the FSM to BUF.
- `sink_ready` by state:
  - IDLE, BUF, SKIP: `sink_ready` = 1.
  - PASS: `sink_ready` = `source_ready`.
  - DRAIN: `sink_ready` = 0.
- Non-sop samples in IDLE are dropped silently.
- Accepted sop outside IDLE:
  - Abort the current frame and pulse `source_error[0]`.
  - If output was already started, no eop is emitted for it.
  - Restart at k=0 with the new frame.
- `sink_eop` asserted on k≠N−1, or absent on k=N−1: pulse `source_error[1]`; position still follows k, not eop.
- `sink_error` is ignored.
- No arithmetic is applied. Samples are bit-exact copies; the width is unchanged.

## Timing
- Reset values: `source_valid`=0, `source_sop`=0, `source_eop`=0, `source_real`=0, `source_imag`=0, `source_error`=0, `fftpts_out`=0, `sink_ready`=1, state IDLE, counters 0.
- Reset mid-frame or mid-drain discards everything; buffer contents need not be cleared.
- PASS latency: the sample accepted at edge t appears on source registers after edge t+1 (1 cycle).
- DRAIN: the first buffered sample is on the output 2 cycles after acceptance of k=N−1. Output is gapless while `source_ready`=1; the buffer read has 1-cycle latency.
- `source_ready`=0 freezes the output registers, buffer read address and pipeline; no beat is lost or duplicated.
- Frame turnaround: IDLE is entered on the cycle the eop beat is registered. `sink_ready` rises the same cycle, so back-to-back frames have zero idle cycles beyond the DRAIN stall.
- Throughput: one input per cycle except during DRAIN (H cycles of `sink_ready`=0 per frame).

## Test plan
- N=2048, H=600, input real=k, imag=−k, `source_ready`=1.
  - Expect exactly 1200 beats.
  - out0 = (1448,−1448) with sop; out599 = 2047; out600 = 1; out1199 = 600 with eop.
  - `fftpts_out`=2048.
  - First beat 1 cycle after k=1448 is accepted.
- N=128, H=36, same ramp: out0=92, out35=127, out36=1, out71=36; `sink_ready` low for exactly 36 cycles.
- N=2048, H=600 with `source_ready` randomly toggled at 50%: the output sequence is identical to the first scenario, with no gaps in data order, and there are no drops or duplicates.
- Two back-to-back N=512, H=150 frames (second frame ramp offset +1000): the second frame's out0 = 1362, and its sop is accepted on the first cycle `sink_ready` returns high.
- A new sop at k=700 of an N=2048 frame: `source_error[0]` pulses once, no eop is emitted for the aborted frame, and the new frame output matches the first scenario.
- `rst_n` asserted low mid-DRAIN: all source outputs are 0 immediately (asynchronous). After release, `sink_ready`=1 and the next full frame output is correct.
